// File: rtl/fp_div_iter_if.sv
// Valid/ready operand and result bundle for fp_div_iter.
// Flag order used across the block: {invalid, div_by_zero, overflow, underflow}.
`timescale 1ns/1ps
interface fp_div_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] div_res;
  logic         div_by_zero;
  logic         overflow;
  logic         underflow;
  logic         invalid;

  modport master (
    output in_valid, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, div_res, div_by_zero, overflow, underflow, invalid
  );

  modport slave (
    input  in_valid, operand_a, operand_b, out_ready,
    output in_ready, out_valid, div_res, div_by_zero, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp_div_iter.sv
// Multi-cycle IEEE-754-style divider: radix-2 restoring mantissa divide, RNE rounding.
// Optional FP_DIV_ITER_STICKY_EN adds flag_clr / sticky_flags accumulation.
`timescale 1ns/1ps
module fp_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef FP_DIV_ITER_STICKY_EN
  input  logic         flag_clr,
  output logic [3:0]   sticky_flags,
`endif
  fp_div_iter_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int Q     = MAN_W + 3;
  localparam int CNT_W = $clog2(Q);
  localparam int EW    = EXP_W + 2;

  localparam logic signed [EW-1:0] BIAS_S     = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_MAX_S  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE_S  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO_S = '0;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_ROUND, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [MAN_W:0]         div_q, div_d;
  logic [MAN_W+1:0]       rem_q, rem_d;
  logic [Q-1:0]           quo_q, quo_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [W-1:0]           res_q, res_d;
  logic [3:0]             flags_q, flags_d;

  // Operand field decode; subnormals (exp == 0) count as zero.
  logic               sa, sb, s_ab;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sa     = bus.operand_a[W-1];
  assign sb     = bus.operand_b[W-1];
  assign s_ab   = sa ^ sb;
  assign ea     = bus.operand_a[W-2:MAN_W];
  assign eb     = bus.operand_b[W-2:MAN_W];
  assign fa     = bus.operand_a[MAN_W-1:0];
  assign fb     = bus.operand_b[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  // One restoring step: the partial remainder stays below 2*divisor, so MAN_W+2 bits suffice.
  logic             step_ge;
  logic [MAN_W+1:0] rem_sub;

  assign step_ge = (rem_q >= {1'b0, div_q});
  assign rem_sub = step_ge ? (rem_q - {1'b0, div_q}) : rem_q;

  logic                 guard_bit, sticky_bit, round_up;
  logic [MAN_W-1:0]     mant_sel;
  logic [MAN_W:0]       mant_rnd;
  logic signed [EW-1:0] exp_norm, exp_rnd;
  logic [W-1:0]         round_res;
  logic [3:0]           round_flags;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    mant_sel    = quo_q[Q-2:2];
    guard_bit   = quo_q[1];
    sticky_bit  = quo_q[0] | (rem_q != '0);
    exp_norm    = exp_q;
    if (!quo_q[Q-1]) begin
      mant_sel   = quo_q[Q-3:1];
      guard_bit  = quo_q[0];
      sticky_bit = (rem_q != '0);
      exp_norm   = exp_q - EXP_ONE_S;
    end
    round_up = guard_bit & (sticky_bit | mant_sel[0]);
    mant_rnd = {1'b0, mant_sel} + {{MAN_W{1'b0}}, round_up};
    exp_rnd  = mant_rnd[MAN_W] ? (exp_norm + EXP_ONE_S) : exp_norm;

    round_flags = 4'b0000;
    round_res   = {sign_q, exp_rnd[EXP_W-1:0], mant_rnd[MAN_W-1:0]};
    if (exp_rnd >= EXP_MAX_S) begin
      round_res   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      round_flags = 4'b0010;
    end else if (exp_rnd <= EXP_ZERO_S) begin
      round_res   = {sign_q, {(W-1){1'b0}}};
      round_flags = 4'b0001;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flags_d = flags_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          flags_d = 4'b0000;
          sign_d  = s_ab;
          state_d = S_DONE;
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res_d   = QNAN;
            flags_d = 4'b1000;
          end else if (a_inf) begin
            res_d = {s_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          end else if (b_inf || a_zero) begin
            res_d = {s_ab, {(W-1){1'b0}}};
          end else if (b_zero) begin
            res_d   = {s_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d = 4'b0100;
          end else begin
            exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;
            div_d   = {1'b1, fb};
            rem_d   = {1'b0, 1'b1, fa};
            quo_d   = '0;
            cnt_d   = '0;
            state_d = S_DIVIDE;
          end
        end
      end
      S_DIVIDE: begin
        rem_d = {rem_sub[MAN_W:0], 1'b0};
        quo_d = {quo_q[Q-2:0], step_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(Q - 1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        res_d   = round_res;
        flags_d = round_flags;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.div_res     = res_q;
  assign bus.invalid     = flags_q[3];
  assign bus.div_by_zero = flags_q[2];
  assign bus.overflow    = flags_q[1];
  assign bus.underflow   = flags_q[0];

`ifdef FP_DIV_ITER_STICKY_EN
  logic [3:0] sticky_q;

  // Clear has priority over a same-cycle handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else if (flag_clr) begin
      sticky_q <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      sticky_q <= sticky_q | flags_q;
    end
  end

  assign sticky_flags = sticky_q;
`endif
endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter: the driver queues expected results, a monitor checks each output.
// Define FP_DIV_ITER_STICKY_EN to also exercise the sticky flag register.
`timescale 1ns/1ps
module tb_fp_div_iter;
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_INV  = 4'b1000;
  localparam logic [3:0] F_DBZ  = 4'b0100;
  localparam logic [3:0] F_OVF  = 4'b0010;
  localparam logic [3:0] F_UNF  = 4'b0001;
  localparam int LAT_NORM = 28;
  localparam int LAT_SPEC = 1;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          issue_cyc;
    int          lat;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  logic prev_valid;
  exp_t sb_q[$];
  exp_t mon_e;

  fp_div_iter_if bus ();

`ifdef FP_DIV_ITER_STICKY_EN
  logic       flag_clr;
  logic [3:0] sticky_flags;
`endif

  fp_div_iter dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef FP_DIV_ITER_STICKY_EN
    .flag_clr     (flag_clr),
    .sticky_flags (sticky_flags),
`endif
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [3:0] dut_flags();
    return {bus.invalid, bus.div_by_zero, bus.overflow, bus.underflow};
  endfunction

  // Monitor: compares on the first cycle each result is presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_out", 32'(sb_q.size()), 32'd1);
        end else begin
          mon_e = sb_q.pop_front();
          check({mon_e.name, "_res"}, bus.div_res, mon_e.res);
          check({mon_e.name, "_flags"}, {28'd0, dut_flags()}, {28'd0, mon_e.flags});
          check({mon_e.name, "_lat"}, 32'(cyc - mon_e.issue_cyc), 32'(mon_e.lat));
        end
      end
      prev_valid <= bus.out_valid;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                       input logic [3:0] flags, input int lat, input string name);
    exp_t e;
    int   n;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check({name, "_in_ready_wait"}, {31'd0, bus.in_ready}, 32'd1);
      return;
    end
    bus.operand_a = a;
    bus.operand_b = b;
    bus.in_valid  = 1'b1;
    e.res       = res;
    e.flags     = flags;
    e.issue_cyc = cyc;
    e.lat       = lat;
    e.name      = name;
    sb_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !bus.in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    cyc           = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.out_ready = 1'b1;
`ifdef FP_DIV_ITER_STICKY_EN
    flag_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_div_res", bus.div_res, 32'h0);
    check("rst_flags", {28'd0, dut_flags()}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h41200000, 32'h40A00000, 32'h40000000, F_NONE, LAT_NORM, "ten_div_five");
    issue(32'hBF4CCCCD, 32'hBF000000, 32'h3FCCCCCD, F_NONE, LAT_NORM, "neg_div_neg");
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, F_NONE, LAT_NORM, "one_third");
    issue(32'h40A00000, 32'h00000000, 32'h7F800000, F_DBZ,  LAT_SPEC, "div_zero");
    issue(32'h00000000, 32'h00000000, 32'h7FC00000, F_INV,  LAT_SPEC, "zero_zero");
    issue(32'h80000000, 32'h40000000, 32'h80000000, F_NONE, LAT_SPEC, "negzero_div");
    issue(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, F_OVF,  LAT_NORM, "overflow");
    issue(32'h00800000, 32'h40000000, 32'h00000000, F_UNF,  LAT_NORM, "underflow");
    issue(32'h7F800000, 32'h7F800000, 32'h7FC00000, F_INV,  LAT_SPEC, "inf_inf");
    issue(32'hFF800000, 32'h40000000, 32'hFF800000, F_NONE, LAT_SPEC, "neginf_div");
    issue(32'h40000000, 32'hFF800000, 32'h80000000, F_NONE, LAT_SPEC, "div_neginf");
    issue(32'h7FC00001, 32'h3F800000, 32'h7FC00000, F_INV,  LAT_SPEC, "nan_in");
    drain();

    // Back-pressure: result must hold and new operands must be ignored.
    bus.out_ready = 1'b0;
    issue(32'h41200000, 32'h40A00000, 32'h40000000, F_NONE, LAT_NORM, "hold");
    for (int i = 0; i < 40 && !bus.out_valid; i++) @(negedge clk);
    bus.operand_a = 32'h3F800000;
    bus.operand_b = 32'h40400000;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("hold_res", bus.div_res, 32'h40000000);
      check("hold_flags", {28'd0, dut_flags()}, 32'd0);
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("hold_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    drain();

`ifdef FP_DIV_ITER_STICKY_EN
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    check("sticky_cleared", {28'd0, sticky_flags}, 32'd0);
    issue(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, F_OVF, LAT_NORM, "sticky_ovf");
    issue(32'h40A00000, 32'h00000000, 32'h7F800000, F_DBZ, LAT_SPEC, "sticky_dbz");
    drain();
    check("sticky_accum", {28'd0, sticky_flags}, 32'b0110);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    check("sticky_clr", {28'd0, sticky_flags}, 32'd0);
`endif

    // Reset in the middle of a divide must abort it without a result.
    bus.operand_a = 32'h41200000;
    bus.operand_b = 32'h40A00000;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_div_res", bus.div_res, 32'h0);
    rst_n = 1'b1;
    repeat (35) @(negedge clk);
    check("mid_rst_no_output", {31'd0, bus.out_valid}, 32'd0);
    check("final_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
